// File: rtl/apb4_cmd_master.sv
// Single-outstanding command-to-APB4 bridge: one request in, one APB transfer,
// one response out, with an optional bound on slave wait states.
module apb4_cmd_master #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter int TIMEOUT    = 16
) (
  input  logic                    pclk,
  input  logic                    preset,
  input  logic                    cmd_valid,
  output logic                    cmd_ready,
  input  logic                    cmd_write,
  input  logic [ADDR_WIDTH-1:0]   cmd_addr,
  input  logic [DATA_WIDTH-1:0]   cmd_wdata,
  input  logic [DATA_WIDTH/8-1:0] cmd_strb,
  input  logic [2:0]              cmd_prot,
  output logic                    rsp_valid,
  input  logic                    rsp_ready,
  output logic [DATA_WIDTH-1:0]   rsp_rdata,
  output logic                    rsp_err,
  output logic                    rsp_timeout,
  output logic [ADDR_WIDTH-1:0]   paddr,
  output logic                    psel,
  output logic                    penable,
  output logic                    pwrite,
  output logic [DATA_WIDTH-1:0]   pwdata,
  output logic [DATA_WIDTH/8-1:0] pstrb,
  output logic [2:0]              pprot,
  input  logic                    pready,
  input  logic [DATA_WIDTH-1:0]   prdata,
  input  logic                    pslverr
);

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_SETUP  = 2'd1;
  localparam logic [1:0] S_ACCESS = 2'd2;
  localparam logic [1:0] S_RESP   = 2'd3;

  // A zero-width counter is illegal, so TIMEOUT=0 still gets one (unused) bit.
  localparam int              CW   = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [CW-1:0]   TMAX = CW'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);

  logic [1:0]              r_state;
  logic [CW-1:0]           r_cnt;
  logic                    r_psel, r_penable, r_pwrite;
  logic [ADDR_WIDTH-1:0]   r_paddr;
  logic [DATA_WIDTH-1:0]   r_pwdata;
  logic [DATA_WIDTH/8-1:0] r_pstrb;
  logic [2:0]              r_pprot;
  logic                    r_rsp_valid, r_rsp_err, r_rsp_timeout;
  logic [DATA_WIDTH-1:0]   r_rsp_rdata;
  logic                    w_timeout;

  assign w_timeout = (TIMEOUT > 0) && (r_cnt == TMAX);
  assign cmd_ready = (r_state == S_IDLE) && !preset;

  always_ff @(posedge pclk) begin
    if (preset) begin
      r_state       <= S_IDLE;
      r_cnt         <= '0;
      r_psel        <= 1'b0;
      r_penable     <= 1'b0;
      r_pwrite      <= 1'b0;
      r_paddr       <= '0;
      r_pwdata      <= '0;
      r_pstrb       <= '0;
      r_pprot       <= '0;
      r_rsp_valid   <= 1'b0;
      r_rsp_rdata   <= '0;
      r_rsp_err     <= 1'b0;
      r_rsp_timeout <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (cmd_valid) begin
            r_paddr  <= cmd_addr;
            r_pwrite <= cmd_write;
            r_pwdata <= cmd_wdata;
            r_pstrb  <= cmd_write ? cmd_strb : '0;
            r_pprot  <= cmd_prot;
            r_psel   <= 1'b1;
            r_cnt    <= '0;
            r_state  <= S_SETUP;
          end
        end
        S_SETUP: begin
          r_penable <= 1'b1;
          r_state   <= S_ACCESS;
        end
        S_ACCESS: begin
          if (pready) begin
            r_rsp_rdata   <= r_pwrite ? '0 : prdata;
            r_rsp_err     <= pslverr;
            r_rsp_timeout <= 1'b0;
            r_rsp_valid   <= 1'b1;
            r_psel        <= 1'b0;
            r_penable     <= 1'b0;
            r_state       <= S_RESP;
          end else if (w_timeout) begin
            r_rsp_rdata   <= '0;
            r_rsp_err     <= 1'b1;
            r_rsp_timeout <= 1'b1;
            r_rsp_valid   <= 1'b1;
            r_psel        <= 1'b0;
            r_penable     <= 1'b0;
            r_state       <= S_RESP;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        default: begin
          if (rsp_ready) begin
            r_rsp_valid <= 1'b0;
            r_state     <= S_IDLE;
          end
        end
      endcase
    end
  end

  assign psel        = r_psel;
  assign penable     = r_penable;
  assign pwrite      = r_pwrite;
  assign paddr       = r_paddr;
  assign pwdata      = r_pwdata;
  assign pstrb       = r_pstrb;
  assign pprot       = r_pprot;
  assign rsp_valid   = r_rsp_valid;
  assign rsp_rdata   = r_rsp_rdata;
  assign rsp_err     = r_rsp_err;
  assign rsp_timeout = r_rsp_timeout;

endmodule

// File: tb/tb_apb4_cmd_master.sv
// Cycle-by-cycle vector table for apb4_cmd_master (TIMEOUT=4): each row holds the
// outputs expected in that cycle and the inputs driven for the next edge.
module tb_apb4_cmd_master;

  logic        pclk = 1'b0;
  logic        preset;
  logic        cmd_valid, cmd_ready, cmd_write;
  logic [31:0] cmd_addr, cmd_wdata;
  logic [3:0]  cmd_strb;
  logic [2:0]  cmd_prot;
  logic        rsp_valid, rsp_ready, rsp_err, rsp_timeout;
  logic [31:0] rsp_rdata;
  logic [31:0] paddr, pwdata, prdata;
  logic        psel, penable, pwrite, pready, pslverr;
  logic [3:0]  pstrb;
  logic [2:0]  pprot;

  always #5 pclk = ~pclk;

  apb4_cmd_master #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .TIMEOUT(4)) dut (
    .pclk(pclk), .preset(preset),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
    .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata), .cmd_strb(cmd_strb), .cmd_prot(cmd_prot),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata),
    .rsp_err(rsp_err), .rsp_timeout(rsp_timeout),
    .paddr(paddr), .psel(psel), .penable(penable), .pwrite(pwrite),
    .pwdata(pwdata), .pstrb(pstrb), .pprot(pprot),
    .pready(pready), .prdata(prdata), .pslverr(pslverr)
  );

  typedef struct {
    logic        rst, cv, cw;
    logic [31:0] ca, cd;
    logic [3:0]  cs;
    logic [2:0]  cp;
    logic        pr;
    logic [31:0] prd;
    logic        pe, rr;
    logic        x_crdy, x_sel, x_en, x_wr;
    logic [31:0] x_addr, x_wd;
    logic [3:0]  x_strb;
    logic [2:0]  x_prot;
    logic        x_rv;
    logic [31:0] x_rd;
    logic        x_err, x_to;
  } vec_t;

  vec_t cur;
  vec_t tbl[$];
  int   n_vec = 0;
  int   n_bad = 0;

  task automatic I(input logic rst, cv, cw, input logic [31:0] ca, cd,
                   input logic [3:0] cs, input logic [2:0] cp, input logic pr,
                   input logic [31:0] prd, input logic pe, rr);
    cur.rst = rst; cur.cv = cv; cur.cw = cw; cur.ca = ca; cur.cd = cd;
    cur.cs = cs; cur.cp = cp; cur.pr = pr; cur.prd = prd; cur.pe = pe; cur.rr = rr;
  endtask

  task automatic E(input logic crdy, sel, en, wr, input logic [31:0] addr, wd,
                   input logic [3:0] strb, input logic [2:0] prot, input logic rv,
                   input logic [31:0] rd, input logic err, to);
    cur.x_crdy = crdy; cur.x_sel = sel; cur.x_en = en; cur.x_wr = wr;
    cur.x_addr = addr; cur.x_wd = wd; cur.x_strb = strb; cur.x_prot = prot;
    cur.x_rv = rv; cur.x_rd = rd; cur.x_err = err; cur.x_to = to;
    tbl.push_back(cur);
  endtask

  task automatic drive(input vec_t v);
    preset = v.rst; cmd_valid = v.cv; cmd_write = v.cw; cmd_addr = v.ca;
    cmd_wdata = v.cd; cmd_strb = v.cs; cmd_prot = v.cp; pready = v.pr;
    prdata = v.prd; pslverr = v.pe; rsp_ready = v.rr;
  endtask

  task automatic check(input int idx, input vec_t v);
    logic [109:0] act, exp;
    act = {cmd_ready, psel, penable, pwrite, paddr, pwdata, pstrb, pprot,
           rsp_valid, rsp_rdata, rsp_err, rsp_timeout};
    exp = {v.x_crdy, v.x_sel, v.x_en, v.x_wr, v.x_addr, v.x_wd, v.x_strb, v.x_prot,
           v.x_rv, v.x_rd, v.x_err, v.x_to};
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL row%0d got {rdy sel en wr addr wd strb prot rv rd err to}=%b %b %b %b %h %h %h %h %b %h %b %b want %b %b %b %b %h %h %h %h %b %h %b %b",
        idx, cmd_ready, psel, penable, pwrite, paddr, pwdata, pstrb, pprot, rsp_valid, rsp_rdata, rsp_err, rsp_timeout,
        v.x_crdy, v.x_sel, v.x_en, v.x_wr, v.x_addr, v.x_wd, v.x_strb, v.x_prot, v.x_rv, v.x_rd, v.x_err, v.x_to);
    end
  endtask

  initial begin
    // reset held, then released
    I(1,0,0,0,0,0,0,0,0,0,0);                       E(0,0,0,0,0,0,0,0,0,0,0,0);
    I(0,0,0,0,0,0,0,0,0,0,0);                       E(0,0,0,0,0,0,0,0,0,0,0,0);
    // best-case write
    I(0,1,1,'h10,'hA5A50001,'hF,2,1,0,0,1);         E(1,0,0,0,0,0,0,0,0,0,0,0);
    I(0,0,0,0,0,0,0,1,0,0,1);                       E(0,1,0,1,'h10,'hA5A50001,'hF,2,0,0,0,0);
    I(0,0,0,0,0,0,0,1,'h99999999,0,1);              E(0,1,1,1,'h10,'hA5A50001,'hF,2,0,0,0,0);
    I(0,0,0,0,0,0,0,0,0,0,1);                       E(0,0,0,1,'h10,'hA5A50001,'hF,2,1,0,0,0);
    // read with three wait states; pready/pslverr in SETUP are ignored
    I(0,1,0,'h20,0,'hF,0,0,0,0,1);                  E(1,0,0,1,'h10,'hA5A50001,'hF,2,0,0,0,0);
    I(0,0,0,0,0,0,0,1,'h12121212,1,1);              E(0,1,0,0,'h20,0,0,0,0,0,0,0);
    I(0,0,0,0,0,0,0,0,0,0,1);                       E(0,1,1,0,'h20,0,0,0,0,0,0,0);
    I(0,0,0,0,0,0,0,0,0,0,1);                       E(0,1,1,0,'h20,0,0,0,0,0,0,0);
    I(0,0,0,0,0,0,0,0,0,0,1);                       E(0,1,1,0,'h20,0,0,0,0,0,0,0);
    I(0,0,0,0,0,0,0,1,'hDEADBEEF,0,1);              E(0,1,1,0,'h20,0,0,0,0,0,0,0);
    I(0,0,0,0,0,0,0,0,0,0,1);                       E(0,0,0,0,'h20,0,0,0,1,'hDEADBEEF,0,0);
    // read that times out after exactly 4 ACCESS cycles
    I(0,1,0,'h30,0,0,0,0,0,0,1);                    E(1,0,0,0,'h20,0,0,0,0,'hDEADBEEF,0,0);
    I(0,0,0,0,0,0,0,0,0,0,1);                       E(0,1,0,0,'h30,0,0,0,0,'hDEADBEEF,0,0);
    for (int k = 0; k < 4; k++) begin
      I(0,0,0,0,0,0,0,0,0,0,1);                     E(0,1,1,0,'h30,0,0,0,0,'hDEADBEEF,0,0);
    end
    I(0,0,0,0,0,0,0,0,0,0,1);                       E(0,0,0,0,'h30,0,0,0,1,0,1,1);
    // write with pslverr, response back-pressured for 5 cycles
    I(0,1,1,'h40,'h12345678,'h3,1,0,0,0,1);         E(1,0,0,0,'h30,0,0,0,0,0,1,1);
    I(0,0,0,0,0,0,0,0,0,0,1);                       E(0,1,0,1,'h40,'h12345678,'h3,1,0,0,1,1);
    I(0,0,0,0,0,0,0,1,'hFFFFFFFF,1,1);              E(0,1,1,1,'h40,'h12345678,'h3,1,0,0,1,1);
    for (int k = 0; k < 5; k++) begin
      I(0,1,0,'h44,0,0,0,0,0,0,0);                  E(0,0,0,1,'h40,'h12345678,'h3,1,1,0,1,0);
    end
    I(0,0,0,0,0,0,0,0,0,0,1);                       E(0,0,0,1,'h40,'h12345678,'h3,1,1,0,1,0);
    // reset pulse during ACCESS, then a clean read
    I(0,1,0,'h50,0,'hF,5,0,0,0,1);                  E(1,0,0,1,'h40,'h12345678,'h3,1,0,0,1,0);
    I(0,0,0,0,0,0,0,0,0,0,1);                       E(0,1,0,0,'h50,0,0,5,0,0,1,0);
    I(1,0,0,0,0,0,0,1,'h55555555,0,1);              E(0,1,1,0,'h50,0,0,5,0,0,1,0);
    I(0,0,0,0,0,0,0,0,0,0,1);                       E(0,0,0,0,0,0,0,0,0,0,0,0);
    I(0,1,0,'h60,0,0,0,1,'h0BADF00D,0,1);           E(1,0,0,0,0,0,0,0,0,0,0,0);
    I(0,0,0,0,0,0,0,1,'h0BADF00D,0,1);              E(0,1,0,0,'h60,0,0,0,0,0,0,0);
    I(0,0,0,0,0,0,0,1,'hCAFE0001,0,1);              E(0,1,1,0,'h60,0,0,0,0,0,0,0);
    // back-to-back writes, cmd_valid held high; next command shown early
    I(0,1,1,'h70,'h11,'hF,0,1,0,0,1);               E(0,0,0,0,'h60,0,0,0,1,'hCAFE0001,0,0);
    I(0,1,1,'h70,'h11,'hF,0,1,0,0,1);               E(1,0,0,0,'h60,0,0,0,0,'hCAFE0001,0,0);
    I(0,1,1,'h74,'h22,'hF,0,1,0,0,1);               E(0,1,0,1,'h70,'h11,'hF,0,0,'hCAFE0001,0,0);
    I(0,1,1,'h74,'h22,'hF,0,1,0,0,1);               E(0,1,1,1,'h70,'h11,'hF,0,0,'hCAFE0001,0,0);
    I(0,1,1,'h74,'h22,'hF,0,1,0,0,1);               E(0,0,0,1,'h70,'h11,'hF,0,1,0,0,0);
    I(0,1,1,'h74,'h22,'hF,0,1,0,0,1);               E(1,0,0,1,'h70,'h11,'hF,0,0,0,0,0);
    I(0,0,0,0,0,0,0,1,0,0,1);                       E(0,1,0,1,'h74,'h22,'hF,0,0,0,0,0);
    I(0,0,0,0,0,0,0,1,0,0,1);                       E(0,1,1,1,'h74,'h22,'hF,0,0,0,0,0);
    I(0,0,0,0,0,0,0,0,0,0,1);                       E(0,0,0,1,'h74,'h22,'hF,0,1,0,0,0);
    I(0,0,0,0,0,0,0,0,0,0,1);                       E(1,0,0,1,'h74,'h22,'hF,0,0,0,0,0);

    drive(tbl[0]);
    preset = 1'b1;
    @(posedge pclk);
    foreach (tbl[i]) begin
      @(negedge pclk);
      check(i, tbl[i]);
      drive(tbl[i]);
    end

    // Timeout read again, measured by a bounded wait instead of per-cycle rows
    begin
      int  acc_cycles;
      bit  seen;
      acc_cycles = 0;
      seen = 1'b0;
      @(negedge pclk);
      cmd_valid = 1'b1; cmd_write = 1'b0; cmd_addr = 32'h80; pready = 1'b0;
      @(negedge pclk);
      cmd_valid = 1'b0;
      for (int c = 0; c < 20 && !seen; c++) begin
        @(negedge pclk);
        if (psel && penable) acc_cycles++;
        if (rsp_valid) seen = 1'b1;
      end
      n_vec++;
      if (!seen) begin
        n_bad++;
        $display("FAIL to_wait rsp_valid not seen within 20 cycles, want it after 4 ACCESS cycles");
      end
      n_vec++;
      if (acc_cycles != 4 || rsp_err !== 1'b1 || rsp_timeout !== 1'b1 || rsp_rdata !== 32'h0 || psel !== 1'b0) begin
        n_bad++;
        $display("FAIL to_seq got acc=%0d err=%b to=%b rd=%h psel=%b want acc=4 err=1 to=1 rd=00000000 psel=0",
                 acc_cycles, rsp_err, rsp_timeout, rsp_rdata, psel);
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
